// File: rtl/fft_sdf_controller.sv
// Sequencing controller for a radix-2 single-path delay-feedback FFT: input handshake,
// per-stage commutator phase and twiddle addressing, output framing and pipeline drain.
// Define FFT_CTRL_AUTOFLUSH_EN to drain automatically after N idle cycles at a frame boundary.
module fft_sdf_controller #(
  parameter  int N = 8,
  localparam int S = $clog2(N),
  localparam int L = N - 1 + S
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush_req,
  output logic               pipe_en,
  output logic [S-1:0]       stage_sel,
  output logic [S*(S-1)-1:0] tw_addr,
  output logic               out_valid,
  output logic               out_last,
  output logic               busy,
  output logic               flush_err
);
  localparam int TWW = S - 1;
  localparam int DW  = $clog2(L);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [S-1:0]  icnt_q, icnt_d;
  logic [S-1:0]  acnt_q, acnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [L-1:0]  vsr_q, vsr_d;
  logic [L-1:0]  lsr_q, lsr_d;
  logic          flush_err_q, flush_err_d;
  logic          accept, at_boundary, auto_flush;
`ifdef FFT_CTRL_AUTOFLUSH_EN
  logic [S-1:0]  idle_q, idle_d;
`endif

  // Stage k sees the global advance count delayed by all upstream delay lines and butterfly registers.
  function automatic int stage_offset(input int k);
    int s;
    s = k;
    for (int j = 0; j < k; j++) s += N >> (j + 1);
    return s;
  endfunction

  assign in_ready    = (state_q != DRAIN);
  assign accept      = in_valid && in_ready;
  assign pipe_en     = (state_q == DRAIN) || accept;
  assign at_boundary = (state_q == RUN) && (icnt_q == {S{1'b0}}) && !accept;
  assign out_valid   = pipe_en && vsr_q[L-1];
  assign out_last    = pipe_en && lsr_q[L-1];
  assign busy        = (state_q != IDLE);
  assign flush_err   = flush_err_q;

`ifdef FFT_CTRL_AUTOFLUSH_EN
  assign auto_flush = at_boundary && (idle_q == S'(N - 1));
`else
  assign auto_flush = 1'b0;
`endif

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam logic [S-1:0] OFF  = S'(stage_offset(k) % N);
    localparam logic [S-1:0] MASK = S'((N >> (k + 1)) - 1);
    logic [S-1:0] ck;
    assign ck                       = acnt_q - OFF;
    assign stage_sel[k]             = ck[S-1-k];
    assign tw_addr[k*TWW +: TWW]    = TWW'((ck & MASK) << k);
  end

  // Next-state computation for the FSM, counters and tracking shift registers.
  always_comb begin
    state_d     = state_q;
    icnt_d      = icnt_q;
    acnt_d      = acnt_q;
    dcnt_d      = dcnt_q;
    vsr_d       = vsr_q;
    lsr_d       = lsr_q;
    flush_err_d = 1'b0;
`ifdef FFT_CTRL_AUTOFLUSH_EN
    idle_d      = {S{1'b0}};
`endif
    if (accept) begin
      icnt_d = icnt_q + S'(1);
    end else begin
      icnt_d = icnt_q;
    end
    if (pipe_en) begin
      acnt_d = acnt_q + S'(1);
      vsr_d  = {vsr_q[L-2:0], accept};
      lsr_d  = {lsr_q[L-2:0], accept && (icnt_q == S'(N - 1))};
    end else begin
      acnt_d = acnt_q;
    end
    case (state_q)
      IDLE: begin
        if (accept) state_d = RUN;
        else        state_d = IDLE;
      end
      RUN: begin
        flush_err_d = flush_req && (icnt_q != {S{1'b0}});
`ifdef FFT_CTRL_AUTOFLUSH_EN
        if (at_boundary && (idle_q != S'(N - 1))) idle_d = idle_q + S'(1);
        else                                      idle_d = {S{1'b0}};
`endif
        if (at_boundary && (flush_req || auto_flush)) begin
          state_d = DRAIN;
          dcnt_d  = {DW{1'b0}};
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (dcnt_q == DW'(L - 1)) begin
          state_d = IDLE;
          dcnt_d  = {DW{1'b0}};
        end else begin
          dcnt_d  = dcnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All controller state, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      icnt_q      <= {S{1'b0}};
      acnt_q      <= {S{1'b0}};
      dcnt_q      <= {DW{1'b0}};
      vsr_q       <= {L{1'b0}};
      lsr_q       <= {L{1'b0}};
      flush_err_q <= 1'b0;
`ifdef FFT_CTRL_AUTOFLUSH_EN
      idle_q      <= {S{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      icnt_q      <= icnt_d;
      acnt_q      <= acnt_d;
      dcnt_q      <= dcnt_d;
      vsr_q       <= vsr_d;
      lsr_q       <= lsr_d;
      flush_err_q <= flush_err_d;
`ifdef FFT_CTRL_AUTOFLUSH_EN
      idle_q      <= idle_d;
`endif
    end
  end

endmodule

// File: tb/tb_fft_sdf_controller.sv
// Scoreboard bench for fft_sdf_controller: a frame-level reference model predicts every
// cycle's outputs and every sample's framing; a negedge monitor pops and compares.
module tb_fft_sdf_controller;
  localparam int N   = 8;
  localparam int S   = $clog2(N);
  localparam int L   = N - 1 + S;
  localparam int TWW = S - 1;
  localparam int TW  = S * (S - 1);

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, flush_req, pipe_en;
  logic [S-1:0]  stage_sel;
  logic [TW-1:0] tw_addr;
  logic out_valid, out_last, busy, flush_err;

  typedef struct packed {
    logic in_ready, pipe_en, out_valid, out_last, busy, flush_err;
    logic [S-1:0]  sel;
    logic [TW-1:0] tw;
  } exp_t;

  exp_t exp_q[$];
  bit   samp_q[$];
  int   checks = 0, failures = 0, out_seen = 0, last_seen = 0;

  // Reference model: mode 0=idle 1=run 2=drain, absolute advance count and per-advance history.
  int m_mode, m_icnt, m_adv, m_drained, m_idle_run;
  bit m_err;
  bit acc_h[$];
  bit last_h[$];

  fft_sdf_controller #(.N(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .flush_req(flush_req), .pipe_en(pipe_en), .stage_sel(stage_sel), .tw_addr(tw_addr),
    .out_valid(out_valid), .out_last(out_last), .busy(busy), .flush_err(flush_err)
  );

  always #5 clk = ~clk;

  function automatic int off_k(input int k);
    int s;
    s = k;
    for (int j = 0; j < k; j++) s += N >> (j + 1);
    return s;
  endfunction

  function automatic exp_t actual_vec();
    return exp_t'({in_ready, pipe_en, out_valid, out_last, busy, flush_err, stage_sel, tw_addr});
  endfunction

  function automatic exp_t model_out(input bit iv);
    exp_t e;
    bit acc, pe;
    int c, t;
    acc = iv && (m_mode != 2);
    pe  = (m_mode == 2) || acc;
    e.in_ready  = (m_mode != 2);
    e.pipe_en   = pe;
    e.out_valid = pe && (m_adv >= L) && acc_h[m_adv - L];
    e.out_last  = pe && (m_adv >= L) && last_h[m_adv - L];
    e.busy      = (m_mode != 0);
    e.flush_err = m_err;
    e.sel = '0;
    e.tw  = '0;
    for (int k = 0; k < S; k++) begin
      c = ((m_adv - off_k(k)) % N + N) % N;
      e.sel[k] = ((c >> (S - 1 - k)) & 1) != 0;
      t = ((c % (N >> (k + 1))) << k) % (1 << TWW);
      e.tw[k*TWW +: TWW] = TWW'(t);
    end
    return e;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_icnt = 0; m_adv = 0; m_drained = 0; m_idle_run = 0; m_err = 1'b0;
    acc_h.delete(); last_h.delete(); samp_q.delete();
  endtask

  task automatic model_step(input bit iv, input bit fr);
    bit acc, pe, boundary, auto_f;
    int old;
    exp_q.push_back(model_out(iv));
    old = m_icnt;
    acc = iv && (m_mode != 2);
    pe  = (m_mode == 2) || acc;
    if (acc) samp_q.push_back(old == N - 1);
    m_err = (m_mode == 1) && fr && (old != 0);
    if (pe) begin
      acc_h.push_back(acc);
      last_h.push_back(acc && (old == N - 1));
      m_adv++;
    end
    if (acc) m_icnt = (old + 1) % N;
    case (m_mode)
      0: if (acc) m_mode = 1;
      1: begin
        boundary = (old == 0) && !acc;
        m_idle_run = boundary ? m_idle_run + 1 : 0;
`ifdef FFT_CTRL_AUTOFLUSH_EN
        auto_f = (m_idle_run >= N);
`else
        auto_f = 1'b0;
`endif
        if (boundary && (fr || auto_f)) begin
          m_mode = 2; m_drained = 0; m_idle_run = 0;
        end
      end
      default: begin
        m_drained++;
        if (m_drained == L) m_mode = 0;
      end
    endcase
  endtask

  task automatic check_eq(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic cycle(input bit iv, input bit fr);
    reset = 1'b1; in_valid = iv; flush_req = fr;
    model_step(iv, fr);
    @(posedge clk); #1;
  endtask

  task automatic rst_cycle(input bit async_check);
    exp_t e, a;
    in_valid = 1'b0; flush_req = 1'b0; reset = 1'b0;
    model_reset();
    if (async_check) begin
      #1;
      e = model_out(1'b0);
      a = actual_vec();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL async_reset actual=%b expected=%b", a, e);
      end
    end
    exp_q.push_back(model_out(1'b0));
    @(posedge clk); #1;
  endtask

  task automatic frame(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0);
  endtask

  task automatic flush_and_drain();
    cycle(1'b0, 1'b1);
    repeat (L + 2) cycle(1'b0, 1'b0);
  endtask

  // Monitor: compare each cycle's outputs, and each emitted sample's framing bit.
  always @(negedge clk) begin
    exp_t me, ma;
    bit   ml;
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      ma = actual_vec();
      checks++;
      if (ma !== me) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t actual=%b expected=%b (rdy,pe,ov,ol,busy,ferr,sel,tw)",
                 $time, ma, me);
      end
    end
    if (out_valid === 1'b1) begin
      out_seen++;
      if (out_last === 1'b1) last_seen++;
      checks++;
      if (samp_q.size() == 0) begin
        failures++;
        $display("FAIL out_sample t=%0t actual=unexpected_output expected=none", $time);
      end else begin
        ml = samp_q.pop_front();
        if (out_last !== ml) begin
          failures++;
          $display("FAIL out_last t=%0t actual=%b expected=%b", $time, out_last, ml);
        end
      end
    end
  end

  initial begin
    int o0, l0;
    reset = 1'b0; in_valid = 1'b0; flush_req = 1'b0;
    model_reset();
    @(posedge clk); #1;
    repeat (3) rst_cycle(1'b0);

    // Single frame, explicit flush.
    o0 = out_seen; l0 = last_seen;
    frame(N);
    flush_and_drain();
    check_eq("single_frame_outputs", out_seen - o0, N);
    check_eq("single_frame_lasts", last_seen - l0, 1);

    // Two frames back to back.
    o0 = out_seen; l0 = last_seen;
    frame(2 * N);
    flush_and_drain();
    check_eq("two_frame_outputs", out_seen - o0, 2 * N);
    check_eq("two_frame_lasts", last_seen - l0, 2);

    // Flush mid-frame is rejected.
    o0 = out_seen;
    frame(3);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    frame(N - 3);
    flush_and_drain();
    check_eq("rejected_flush_outputs", out_seen - o0, N);

    // Input stall mid-frame.
    o0 = out_seen;
    frame(4);
    repeat (5) cycle(1'b0, 1'b0);
    frame(N - 4);
    flush_and_drain();
    check_eq("stall_frame_outputs", out_seen - o0, N);

    // Reset in the middle of a drain, then a clean frame.
    frame(N);
    cycle(1'b0, 1'b1);
    repeat (4) cycle(1'b0, 1'b0);
    rst_cycle(1'b1);
    rst_cycle(1'b0);
    o0 = out_seen;
    frame(N);
    flush_and_drain();
    check_eq("post_reset_outputs", out_seen - o0, N);

    // Frame left waiting at the boundary with no flush request.
    o0 = out_seen;
    frame(N);
    repeat (N + L + 4) cycle(1'b0, 1'b0);
`ifdef FFT_CTRL_AUTOFLUSH_EN
    check_eq("autoflush_outputs", out_seen - o0, N);
`else
    check_eq("no_autoflush_outputs", out_seen - o0, 0);
`endif
    flush_and_drain();
    check_eq("boundary_frame_total", out_seen - o0, N);

    // Randomized traffic with occasional flush requests.
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 4);
    for (int i = 0; i < 4 * N && m_icnt != 0; i++) cycle(1'b1, 1'b0);
    repeat (L + 2) cycle(1'b0, 1'b0);
    flush_and_drain();
    check_eq("pending_samples", samp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_sdf_controller.md
FFT_SDF_CONTROLLER -- requirements
Module: fft_sdf_controller

Interface
REQ-001 SHALL have parameter N, default 8, FFT size, a power of two, 4 to 1024.
REQ-002 SHALL derive localparams S = log2(N) (stage count) and L = N-1+S (pipeline latency in advances: N-1 delay-line cycles plus one register per butterfly).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream sample available.
REQ-006 in_ready  output  1  controller accepts a sample this cycle.
REQ-007 flush_req  input  1  request to drain the pipeline at a frame boundary.
REQ-008 pipe_en  output  1  advance-enable driven to every butterfly and delay commutator.
REQ-009 stage_sel  output  S  bit k is the commutator/butterfly phase for stage k.
REQ-010 tw_addr  output  S*(S-1)  packed per-stage twiddle ROM addresses, stage k at bits [k*(S-1) +: S-1].
REQ-011 out_valid  output  1  the final butterfly output carries a real sample this cycle.
REQ-012 out_last  output  1  marks the Nth output sample of a frame.
REQ-013 busy  output  1  high in RUN or DRAIN.
REQ-014 flush_err  output  1  one-cycle pulse when flush_req is rejected.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-016 IDLE: in_ready=1, pipe_en=in_valid, and an accepted sample moves the FSM to RUN.
REQ-017 RUN: in_ready=1, pipe_en=in_valid&&in_ready, and the pipeline never advances without an accepted sample.
REQ-018 Input counter icnt (S bits) SHALL increment modulo N on each accepted sample, so a frame is complete when icnt wraps to 0.
REQ-019 RUN->DRAIN SHALL occur when icnt==0, no sample is accepted this cycle, and (flush_req or the auto-flush condition of REQ-031) holds.
REQ-020 DRAIN: in_ready=0, pipe_en=1 every cycle for L cycles (drain counter), then the FSM moves to IDLE and the valid pipeline reads all zero.
REQ-021 flush_req with icnt!=0 in RUN SHALL be ignored and SHALL pulse flush_err for one cycle, and flush_req in IDLE or DRAIN SHALL have no effect.
REQ-022 Global advance counter acnt SHALL increment modulo N on every pipe_en cycle, and per-stage count c_k = (acnt - off_k) mod N, off_k = sum over j<k of (N>>(j+1)) + k.
REQ-023 stage_sel[k] SHALL equal bit (S-1-k) of c_k.
REQ-024 tw_addr stage k SHALL equal (c_k mod (N>>(k+1))) << k, truncated to S-1 bits, and stage S-1 SHALL be 0.
REQ-025 SHALL keep an L-bit valid shift register and an L-bit last shift register that shift only on pipe_en, with inputs accepted-sample and (accepted-sample && icnt==N-1).
REQ-026 out_valid SHALL equal pipe_en && vsr[L-1], and out_last SHALL equal pipe_en && lsr[L-1].
REQ-027 Outputs other than in_ready, pipe_en, out_valid and out_last SHALL be registered or derived only from registers, with no combinational in_valid->in_ready path.
REQ-028 in_valid held low mid-frame SHALL freeze all counters and shift registers, and the frame resumes on the next accepted sample.

Reset
REQ-029 While reset=0: FSM=IDLE, icnt=acnt=drain counter=0, vsr=lsr=0, flush_err=0, busy=0; stage_sel and tw_addr follow from acnt=0.
REQ-030 Reset asserted mid-frame or mid-DRAIN SHALL discard all in-flight tracking, and the first sample after release starts a new frame.

Configuration
REQ-031 With FFT_CTRL_AUTOFLUSH_EN defined, RUN SHALL also enter DRAIN after N consecutive cycles with icnt==0 and in_valid=0. Without the macro, DRAIN is entered only through flush_req.

Verification
REQ-032 N=8, 8 back-to-back samples, then in_valid=0 and a 1-cycle flush_req -> DRAIN for 10 cycles, exactly 8 out_valid pulses with out_last on the 8th, FSM returns to IDLE.
REQ-033 N=8, two frames with no gap -> 16 out_valid pulses, out_last on the 8th and 16th, and the second frame's outputs follow the first frame's with no bubble.
REQ-034 N=8, flush_req while icnt=3 -> flush_err pulse, FSM stays RUN, no extra pipe_en.
REQ-035 N=8, in_valid low for 5 cycles after sample 4 -> pipe_en low for those 5 cycles, stage_sel and tw_addr frozen.
REQ-036 N=8, reset asserted mid-DRAIN -> all outputs return to reset values asynchronously, and a following full frame produces 8 correct outputs.
REQ-037 With FFT_CTRL_AUTOFLUSH_EN, N=8: one frame and no flush_req -> DRAIN entered after 8 idle cycles, then 8 outputs; without the macro there is no DRAIN and no output.
